// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing stream block.
//   region_t : position of a counter inside one axis (display, front porch,
//              sync pulse, back porch), in scan order.
//   total()  : sum of the four region lengths of an axis.
//   VGA640_* : standard 640x480@60 timing (25.175 MHz pixel clock).
package vga_pkg;

    typedef enum logic [1:0] {
        DISP  = 2'd0,
        FP    = 2'd1,
        PULSE = 2'd2,
        BP    = 2'd3
    } region_t;

    localparam int VGA640_HDISP  = 640;
    localparam int VGA640_HFP    = 16;
    localparam int VGA640_HPULSE = 96;
    localparam int VGA640_HBP    = 48;
    localparam int VGA640_VDISP  = 480;
    localparam int VGA640_VFP    = 10;
    localparam int VGA640_VPULSE = 2;
    localparam int VGA640_VBP    = 33;

    function automatic int total(input int disp, input int fp,
                                 input int pulse, input int bp);
        return disp + fp + pulse + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the VGA raster: a counter running 0..TOTAL-1 that wraps to 0,
// with a combinational decode of which region the count is in.
// Ports:
//   CLK, RST : pixel clock, asynchronous active-low reset (count -> 0)
//   en       : advance the count this cycle
//   count    : current position on the axis ($clog2(TOTAL) bits)
//   region   : DISP / FP / PULSE / BP decode of count
//   wrap     : high in the cycle the count goes from TOTAL-1 back to 0
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int DISP_LEN  = VGA640_HDISP,
    parameter int FP_LEN    = VGA640_HFP,
    parameter int PULSE_LEN = VGA640_HPULSE,
    parameter int BP_LEN    = VGA640_HBP,
    localparam int TOTAL    = total(DISP_LEN, FP_LEN, PULSE_LEN, BP_LEN),
    localparam int W        = $clog2(TOTAL)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en,
    output logic [W-1:0] count,
    output region_t      region,
    output logic         wrap
);

    localparam logic [W-1:0] LAST        = W'(TOTAL - 1);
    localparam logic [W-1:0] FP_START    = W'(DISP_LEN);
    localparam logic [W-1:0] PULSE_START = W'(DISP_LEN + FP_LEN);
    localparam logic [W-1:0] BP_START    = W'(DISP_LEN + FP_LEN + PULSE_LEN);

    assign wrap = en && (count == LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Regions are contiguous in scan order, so three thresholds suffice.
    always_comb begin
        region = BP;
        if (count < FP_START) begin
            region = DISP;
        end else if (count < PULSE_START) begin
            region = FP;
        end else if (count < BP_START) begin
            region = PULSE;
        end
    end

endmodule

// File: rtl/vga_timing_stream.sv
// Parametrised VGA timing generator and pixel streamer.
// Generates H/V timing for any mode, pulls pixels from an upstream buffer and
// drives a registered RGB/sync/blank bundle to the VGA DAC. Runs on the pixel
// clock.
// Ports:
//   CLK, RST          : pixel clock, asynchronous active-low reset
//   PIX_DATA          : pixel {R,G,B}, CW bits per channel
//   PIX_VALID         : upstream has a pixel
//   PIX_READY         : pixel is consumed this cycle if PIX_VALID
//   UFLOW_CLR         : clears the sticky UFLOW flag
//   PATTERN_SEL       : selects the internal grid pattern
//   VGA_HS, VGA_VS    : sync outputs, active level HS_POL / VS_POL
//   VGA_BLANK         : 1 = active video
//   VGA_SYNC          : tied 0
//   VGA_R/G/B         : colour channels
//   SOF               : one-cycle pulse with the first active pixel of a frame
//   UFLOW             : sticky underflow flag
// Optional feature: define VGA_TEST_PATTERN_EN to build the grid test pattern
// selected by PATTERN_SEL; without it PATTERN_SEL is ignored.
module vga_timing_stream
    import vga_pkg::*;
#(
    parameter int HDISP  = VGA640_HDISP,
    parameter int HFP    = VGA640_HFP,
    parameter int HPULSE = VGA640_HPULSE,
    parameter int HBP    = VGA640_HBP,
    parameter int VDISP  = VGA640_VDISP,
    parameter int VFP    = VGA640_VFP,
    parameter int VPULSE = VGA640_VPULSE,
    parameter int VBP    = VGA640_VBP,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int CW     = 10,
    parameter logic [3*CW-1:0] UFLOW_COLOR = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [3*CW-1:0] PIX_DATA,
    input  logic            PIX_VALID,
    output logic            PIX_READY,
    input  logic            UFLOW_CLR,
    input  logic            PATTERN_SEL,
    output logic            VGA_HS,
    output logic            VGA_VS,
    output logic            VGA_BLANK,
    output logic            VGA_SYNC,
    output logic [CW-1:0]   VGA_R,
    output logic [CW-1:0]   VGA_G,
    output logic [CW-1:0]   VGA_B,
    output logic            SOF,
    output logic            UFLOW
);

    localparam int HW = $clog2(total(HDISP, HFP, HPULSE, HBP));
    localparam int VW = $clog2(total(VDISP, VFP, VPULSE, VBP));

    localparam logic HS_ACT = HS_POL[0];
    localparam logic VS_ACT = VS_POL[0];

    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    region_t         hreg;
    region_t         vreg;
    logic            h_wrap;
    logic            unused_v_wrap;
    logic            active;
    logic            pattern_on;
    logic            grid_on;
    logic            uflow_set;
    logic [3*CW-1:0] pix_next;
    logic [3*CW-1:0] rgb_q;

    vga_axis_counter #(
        .DISP_LEN (HDISP),
        .FP_LEN   (HFP),
        .PULSE_LEN(HPULSE),
        .BP_LEN   (HBP)
    ) u_hcnt (
        .CLK   (CLK),
        .RST   (RST),
        .en    (1'b1),
        .count (hcnt),
        .region(hreg),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .DISP_LEN (VDISP),
        .FP_LEN   (VFP),
        .PULSE_LEN(VPULSE),
        .BP_LEN   (VBP)
    ) u_vcnt (
        .CLK   (CLK),
        .RST   (RST),
        .en    (h_wrap),
        .count (vcnt),
        .region(vreg),
        .wrap  (unused_v_wrap)
    );

`ifdef VGA_TEST_PATTERN_EN
    // Grid lines every 16 pixels/lines, anchored at the top-left active pixel.
    assign pattern_on = PATTERN_SEL;
    assign grid_on    = (32'(hcnt) % 32'd16 == 32'd0) || (32'(vcnt) % 32'd16 == 32'd0);
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = PATTERN_SEL;
    assign pattern_on         = 1'b0;
    assign grid_on            = 1'b0;
`endif

    assign active = (hreg == DISP) && (vreg == DISP);

    // Handshake: PIX_READY is combinational from the raster position; a pixel
    // transfers in any cycle with PIX_READY && PIX_VALID. Nothing is buffered:
    // an active cycle without a valid pixel is shown as UFLOW_COLOR and that
    // slot is lost rather than retried. RST gates READY so nothing is consumed
    // during reset.
    assign PIX_READY = RST && active && !pattern_on;

    always_comb begin
        pix_next  = '0;
        uflow_set = 1'b0;
        if (active) begin
            if (pattern_on) begin
                pix_next = grid_on ? '1 : '0;
            end else if (PIX_VALID) begin
                pix_next = PIX_DATA;
            end else begin
                pix_next  = UFLOW_COLOR;
                uflow_set = 1'b1;
            end
        end
    end

    // Every output is one register stage behind the counters, so sync, blank
    // and colour stay mutually aligned.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            VGA_HS    <= ~HS_ACT;
            VGA_VS    <= ~VS_ACT;
            VGA_BLANK <= 1'b0;
            rgb_q     <= '0;
            SOF       <= 1'b0;
            UFLOW     <= 1'b0;
        end else begin
            VGA_HS    <= (hreg == PULSE) ? HS_ACT : ~HS_ACT;
            VGA_VS    <= (vreg == PULSE) ? VS_ACT : ~VS_ACT;
            VGA_BLANK <= active;
            rgb_q     <= pix_next;
            SOF       <= (hcnt == '0) && (vcnt == '0);
            // A new underflow in the same cycle as a clear keeps the flag set.
            UFLOW     <= uflow_set || (UFLOW && !UFLOW_CLR);
        end
    end

    assign VGA_SYNC = 1'b0;
    assign VGA_R    = rgb_q[3*CW-1:2*CW];
    assign VGA_G    = rgb_q[2*CW-1:CW];
    assign VGA_B    = rgb_q[CW-1:0];

endmodule

// File: tb/tb_vga_timing_stream.sv
// Bench for vga_timing_stream on a small 14x8 raster (112 cycles per frame).
module tb_vga_timing_stream;

    localparam logic [29:0] TB_UF = 30'h2345_6789;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [29:0] PIX_DATA = '0;
    logic        PIX_VALID = 1'b0;
    logic        PIX_READY;
    logic        UFLOW_CLR = 1'b0;
    logic        PATTERN_SEL = 1'b0;
    logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, SOF, UFLOW;
    logic [9:0]  VGA_R, VGA_G, VGA_B;

    vga_timing_stream #(
        .HDISP(8), .HFP(2), .HPULSE(3), .HBP(1),
        .VDISP(4), .VFP(1), .VPULSE(2), .VBP(1),
        .HS_POL(0), .VS_POL(0), .CW(10), .UFLOW_COLOR(TB_UF)
    ) dut (
        .CLK(CLK), .RST(RST),
        .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .UFLOW_CLR(UFLOW_CLR), .PATTERN_SEL(PATTERN_SEL),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .SOF(SOF), .UFLOW(UFLOW)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    logic [35:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int mh = 0;
    int mv = 0;
    logic m_uflow = 1'b0;
    int xfers = 0;
    int sof_cnt = 0;
    logic [29:0] data_ctr = 30'd1;

    localparam logic [35:0] RESET_BUNDLE = {1'b1, 1'b1, 34'b0};

    function automatic logic [35:0] out_bundle();
        return {VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, SOF, UFLOW, VGA_R, VGA_G, VGA_B};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s h=%0d v=%0d actual=%h required=%h", name, mh, mv, act, exp);
        end
    endtask

    // One pixel-clock cycle: drive inputs, check PIX_READY against the model,
    // queue the expected registered outputs, then compare them after the edge.
    task automatic step(input logic valid, input logic [29:0] data, input logic clr,
                        output logic ready_seen);
        logic        act;
        logic        ready;
        logic        m_pat;
        logic [29:0] rgb;
        logic [35:0] e;
`ifdef VGA_TEST_PATTERN_EN
        m_pat = PATTERN_SEL;
`else
        m_pat = 1'b0;
`endif
        PIX_VALID = valid;
        PIX_DATA  = data;
        UFLOW_CLR = clr;
        act   = (mh < 8) && (mv < 4);
        ready = act && !m_pat;
        if (!act) rgb = '0;
        else if (m_pat) begin
            if ((mh % 16 == 0) || (mv % 16 == 0)) rgb = '1;
            else rgb = '0;
        end
        else if (valid) rgb = data;
        else rgb = TB_UF;
        m_uflow = (act && !valid && !m_pat) || (m_uflow && !clr);
        e = {!(mh >= 10 && mh < 13), !(mv >= 5 && mv < 7), act, 1'b0,
             (mh == 0 && mv == 0), m_uflow, rgb};
        #1;
        ready_seen = PIX_READY;
        check("pix_ready", {35'b0, PIX_READY}, {35'b0, ready});
        if (PIX_READY && PIX_VALID) xfers++;
        exp_q.push_back(e);
        @(posedge CLK);
        mh++;
        if (mh == 14) begin
            mh = 0;
            mv = (mv + 1) % 8;
        end
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_queue empty");
        end else begin
            check("out_bundle", out_bundle(), exp_q.pop_front());
        end
        if (SOF) sof_cnt++;
    endtask

    typedef struct {
        logic        valid;
        logic [29:0] data;
        logic        clr;
        logic        exp_ready;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic rdy;
        for (int i = 0; i < 14; i++) begin
            tbl[i].valid     = (i != 5);
            tbl[i].data      = 30'($urandom_range(1, 32'h3FFF_FFFF));
            tbl[i].clr       = 1'b0;
            tbl[i].exp_ready = (i < 8);
        end

        // Reset state, with upstream offering data.
        PIX_VALID = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", out_bundle(), RESET_BUNDLE);
        check("reset_ready", {35'b0, PIX_READY}, 36'd0);
        RST = 1'b1;

        // First line from the table: one underflow slot at column 5.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].valid, tbl[i].data, tbl[i].clr, rdy);
            check("tbl_ready", {35'b0, rdy}, {35'b0, tbl[i].exp_ready});
        end

        // Rest of frame 1, frame 2 (clear then clear racing a new underflow),
        // frame 3 clean with incrementing data.
        for (int c = 14; c < 336; c++) begin
            logic v, k;
            if (c == 224) begin
                xfers = 0;
            end
            v = !(c >= 112 && c < 224 && mv == 1 && mh == 3);
            k = (c >= 112 && c < 224) && ((mv == 0 && mh == 2) || (mv == 1 && mh == 3));
            step(v, data_ctr, k, rdy);
            data_ctr = data_ctr + 30'd1;
        end
        check("xfers_per_frame", 36'(xfers), 36'd32);
        check("sof_count", 36'(sof_cnt), 36'd3);
        check("uflow_sticky", {35'b0, UFLOW}, 36'd1);

        // Frame 4: PATTERN_SEL high, random valid; clear UFLOW on first cycle.
        PATTERN_SEL = 1'b1;
        for (int c = 0; c < 112; c++) begin
            step(1'($urandom_range(0, 1)), 30'($urandom()), (c == 0), rdy);
        end
`ifdef VGA_TEST_PATTERN_EN
        check("pattern_uflow", {35'b0, UFLOW}, 36'd0);
`endif
        PATTERN_SEL = 1'b0;

        // Reset in the middle of an active line.
        for (int k = 0; k < 300 && !(mh == 4 && mv == 1); k++) begin
            step(1'b1, data_ctr, 1'b0, rdy);
            data_ctr = data_ctr + 30'd1;
        end
        check("reach_midline", {35'b0, (mh == 4 && mv == 1)}, 36'd1);
        RST = 1'b0;
        #1;
        check("midreset_outputs", out_bundle(), RESET_BUNDLE);
        check("midreset_ready", {35'b0, PIX_READY}, 36'd0);
        repeat (2) @(posedge CLK);
        #1;
        check("midreset_hold", out_bundle(), RESET_BUNDLE);
        RST = 1'b1;
        mh = 0;
        mv = 0;
        m_uflow = 1'b0;
        sof_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step(1'b1, data_ctr, 1'b0, rdy);
            data_ctr = data_ctr + 30'd1;
        end
        check("restart_sof", 36'(sof_cnt), 36'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_stream.md
Name: vga_timing_stream

Overview:
- Parametrised successor to the fixed-mode VGA controller.
- Generates horizontal and vertical timing for any mode from parameters, with programmable sync polarity.
- Pulls pixels from an upstream buffer through a valid/ready handshake and drives a registered RGB/sync/blank bundle to the VGA DAC.
- Runs directly on the pixel clock; the PLL lives outside this block.

Parameters:
- HDISP, 640, active pixels per line
- HFP, 16, horizontal front porch (pixels)
- HPULSE, 96, horizontal sync pulse width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VDISP, 480, active lines per frame
- VFP, 10, vertical front porch (lines)
- VPULSE, 2, vertical sync pulse width (lines)
- VBP, 33, vertical back porch (lines)
- HS_POL, 0, active level of VGA_HS
- VS_POL, 0, active level of VGA_VS
- CW, 10, bits per colour channel
- UFLOW_COLOR, '0, 3*CW value driven on underflow, packed {R,G,B}

Ports:
- CLK  in  1  pixel clock
- RST  in  1  asynchronous active-low reset
- PIX_DATA  in  3*CW  pixel {R,G,B}
- PIX_VALID  in  1  upstream has a pixel
- PIX_READY  out  1  block consumes a pixel this cycle if valid
- UFLOW_CLR  in  1  clears sticky UFLOW
- PATTERN_SEL  in  1  selects test pattern (only with TEST_PATTERN_EN)
- VGA_HS, VGA_VS  out  1 each  sync outputs
- VGA_BLANK  out  1  1 = active video
- VGA_SYNC  out  1  tied 0
- VGA_R, VGA_G, VGA_B  out  CW each  colour channels
- SOF  out  1  one-cycle pulse with the first active pixel of each frame
- UFLOW  out  1  sticky underflow flag

Behaviour:
- Totals: HTOTAL = HDISP+HFP+HPULSE+HBP; VTOTAL = VDISP+VFP+VPULSE+VBP.
- Counter widths: hcnt is $clog2(HTOTAL) bits; vcnt is $clog2(VTOTAL) bits.
- Horizontal count: hcnt counts 0..HTOTAL-1 and wraps to 0.
- Vertical count: vcnt increments when hcnt wraps and itself wraps to 0 after VTOTAL-1.
- Region order on both axes: display, front porch, pulse, back porch.
- HS region: HDISP+HFP <= hcnt < HDISP+HFP+HPULSE.
- VS region: same rule on vcnt with the vertical parameters.
- Active region: hcnt < HDISP and vcnt < VDISP.
- PIX_READY is combinational and equals active(hcnt,vcnt). A transfer happens when PIX_READY && PIX_VALID.
- No pixel buffering: an active cycle without a valid pixel is not retried.
- All VGA_* outputs, SOF and UFLOW are registered, giving a latency of 1 cycle from counter state to output. Sync, blank and colour are therefore always mutually aligned.
- Colour mux, in priority order:
  - not active -> 0
  - active and PIX_VALID -> PIX_DATA
  - active and !PIX_VALID -> UFLOW_COLOR, and UFLOW sets
- UFLOW is sticky. UFLOW_CLR clears it, but a simultaneous set wins over clear.
- SOF is registered from hcnt==0 && vcnt==0.
- Reset (asynchronous, RST=0):
  - hcnt=0, vcnt=0
  - VGA_HS=!HS_POL, VGA_VS=!VS_POL
  - VGA_BLANK=0, RGB=0, SOF=0, UFLOW=0
- Reset mid-frame: the frame aborts immediately.
- After reset release: the first cycle has hcnt=vcnt=0, so PIX_READY=1 (if RST is high) and SOF follows 1 cycle later.
- PIX_READY is forced 0 while RST=0.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: when PATTERN_SEL=1, the colour mux replaces pixel data with an internal grid.
  - White where hcnt%16==0 or vcnt%16==0 (active region only), black elsewhere.
  - PIX_READY is forced 0.
  - UFLOW never sets.
- Undefined: PATTERN_SEL is ignored and the logic is not synthesised.

Decomposition:
- Package vga_pkg holds:
  - typedef region_t {DISP, FP, PULSE, BP}
  - function total(disp, fp, pulse, bp)
  - standard 640x480@60 constants
- Natural sub-module: vga_axis_counter (parametrised region counter producing count, region and wrap). It is instantiated twice: H, and V enabled by the H wrap.

Test Plan:
Common test parameters: HDISP=8, HFP=2, HPULSE=3, HBP=1, VDISP=4, VFP=1, VPULSE=2, VBP=1, HS_POL=VS_POL=0, giving HTOTAL=14, VTOTAL=8, 112 cycles per frame.
- Release RST with PIX_VALID=1 -> PIX_READY=1 in the first cycle. SOF=1 one cycle later, then every 112 cycles. VGA_BLANK=1 for 8 of every 14 cycles during lines 0-3.
- Sync timing -> VGA_HS low for exactly 3 cycles, starting 11 cycles after each line's first PIX_READY. VGA_VS low for 28 cycles (lines 5-6) per frame.
- PIX_DATA incrementing, PIX_VALID=1 -> VGA_RGB shows the value accepted 1 cycle earlier. Exactly 32 transfers per frame. Colour is 0 whenever BLANK=0.
- Drop PIX_VALID for one active cycle -> that output pixel equals UFLOW_COLOR and UFLOW=1. It stays 1 until UFLOW_CLR. UFLOW_CLR asserted concurrently with a new underflow keeps it 1.
- Assert RST mid-line -> all outputs return to reset values immediately. The frame restarts at (0,0).
- With VGA_TEST_PATTERN_EN and PATTERN_SEL=1 -> white at output column 0 and row 0 of the active area, black otherwise. PIX_READY=0 and UFLOW stays 0.
